// File: rtl/width_down_converter.sv
// Single-clock serializer: splits each IN_W-bit word into IN_W/OUT_W beats of OUT_W bits,
// valid/ready on both sides, sustained one beat per cycle when fed back-to-back.
module width_down_converter #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_params
            $error("width_down_converter: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    // The output slice is always the "head" of the shift register; shifting moves the
    // next beat into that slice.
    function automatic logic [OUT_W-1:0] head_of(input logic [IN_W-1:0] w);
        if (MSB_FIRST) return w[IN_W-1 -: OUT_W];
        else           return w[OUT_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] shift_of(input logic [IN_W-1:0] w);
        if (MSB_FIRST) return w << OUT_W;
        else           return w >> OUT_W;
    endfunction

    logic [IN_W-1:0]  sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic             take;
    logic             accept;
    logic [IN_W-1:0]  sreg_shifted;

    assign take         = out_valid_q & out_ready;
    assign in_ready     = !reset & (!busy_q | (take & out_last_q));
    assign accept       = in_valid & in_ready;
    assign sreg_shifted = shift_of(sreg_q);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path infers a latch.
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (accept) begin
            sreg_d      = in_data;
            cnt_d       = '0;
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = head_of(in_data);
            out_last_d  = 1'b0;
        end else if (take) begin
            if (out_last_q) begin
                // Word finished with nothing queued: go idle, out_data keeps the last beat.
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                sreg_d     = sreg_shifted;
                cnt_d      = cnt_q + 1'b1;
                out_data_d = head_of(sreg_shifted);
                out_last_d = ((cnt_q + 1'b1) == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: nonblocking so every flop samples the pre-edge values.
        if (reset) begin
            sreg_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
